fpu_addsub_arbiter: RTL and testbench
=====================================

# fpu_addsub_arbiter

Shares one pipelined `fsub` unit between two requesters, for example the integer core's FP issue path and a vector/loader path. Addition is executed on the subtractor by inverting the sign of operand 2. The block provides:
- round-robin arbitration;
- in-flight tracking through the fixed-latency `fsub` pipeline;
- per-requester response FIFOs with credit-based backpressure, so a stalled consumer never blocks the other requester or drops a result.

## Interface
Parameters:
- `LAT`, 1: pipeline latency of the attached `fsub`, in clock edges from input to valid `y`; legal range 1..4.
- `DEPTH`, 4: per-requester response FIFO depth; legal range 2..8.

Ports (index i ∈ {0,1}; 32-bit lanes packed as [32i+31:32i]):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  request i valid.
- `req_ready`  out  2  request i accepted this cycle when high together with `req_valid[i]`.
- `req_sub`  in  2  1 = x1−x2, 0 = x1+x2.
- `req_x1`  in  64  operand 1 per requester, IEEE-754 single precision.
- `req_x2`  in  64  operand 2 per requester.
- `rsp_valid`  out  2  response i head entry valid.
- `rsp_ready`  in  2  consumer i pops the head when high together with `rsp_valid[i]`.
- `rsp_y`  out  64  result per requester.
- `rsp_ovf`  out  2  `fsub` overflow flag captured with the result.
- `fpu_x1`  out  32  registered operand 1 to `fsub`.
- `fpu_x2`  out  32  registered operand 2 to `fsub`, sign already adjusted.
- `fpu_y`  in  32  `fsub` result.
- `fpu_ovf`  in  1  `fsub` overflow.

## Operation
- Per-requester counters:
  - `infl[i]`: number of accepted requests whose results have not yet been written to the FIFO.
  - `occ[i]`: FIFO occupancy.
  - Both counters are registered.
- Eligibility: requester i is eligible when `req_valid[i] && (infl[i]+occ[i] < DEPTH)`. The count check uses only registered values, so a pop in the same cycle does not free a credit until the next cycle.
- Grant:
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the requester ≠ `last` is granted.
  - On every grant, `last` is set to the granted index.
  - `req_ready[i]` equals "eligible and granted". It is combinational from state and `req_valid`.
- Issue register, updated on each accept:
  - `fpu_x1 <= req_x1[i]`.
  - `fpu_x2 <= {req_x2[i][31]^~req_sub[i], req_x2[i][30:0]}`.
  - Cycles with no accept load 0 into both.
  - Operands are not otherwise modified. NaN/denormal handling belongs to `fsub`.
- Tag pipe:
  - `vld[0..LAT]` and `id[0..LAT]` form a shift register. Stage 0 loads (accept, granted index) on every edge.
  - When `vld[LAT]` is set, {`fpu_y`, `fpu_ovf`} is written into FIFO `id[LAT]` and `infl[id[LAT]]` is decremented.
- FIFO: circular buffer with read/write pointers mod DEPTH.
  - Write and pop in the same cycle: `occ` is unchanged and both pointers advance.
  - There is no write bypass. An entry written at edge E is visible on `rsp_*` after E.
  - A write into a full FIFO cannot occur by construction. The bench asserts this never happens.
- Ordering: responses are returned in acceptance order per requester. There is no ordering guarantee across requesters.

## Timing
- Reset (asynchronous, immediate):
  - `req_ready`, `rsp_valid`, `rsp_y`, `rsp_ovf`, `fpu_x1`, `fpu_x2` are all 0.
  - Counters, pointers and `vld` are cleared.
  - `last` is 1, so requester 0 wins the first tie.
- Reset mid-operation: in-flight and buffered results are discarded, and no stale `rsp_valid` appears after release.
- Latency: accept at edge E0, then operands appear on `fpu_x*` after E0. The result is written at edge E0+LAT+1, and `rsp_valid` rises in the following cycle (LAT+1 edges after accept).
- Throughput: one accept per cycle in total. With both requesters continuously eligible, grants strictly alternate.
- Backpressure:
  - A requester with `rsp_ready` low stops being granted after DEPTH outstanding+buffered results.
  - The other requester then receives every grant.

## Test plan
- Add, LAT=1: req0 x1=0x3F800000, x2=0x40000000, sub=0 → `fpu_x2`=0xC0000000 after accept; `rsp_y[31:0]`=0x40400000 with `rsp_valid[0]` 2 edges after accept; `rsp_ovf[0]`=0.
- Subtract: req1 x1=0x3F800000, x2=0x40000000, sub=1 → `fpu_x2`=0x40000000; `rsp_y[63:32]`=0xBF800000.
- Contention:
  - Stimulus: both `req_valid` high for 8 cycles with distinct operands; `rsp_ready`=2'b11.
  - Required response: grant order 0,1,0,1,… starting with 0 after reset; each requester receives 4 results in issue order.
- Backpressure, DEPTH=4:
  - `rsp_ready[0]`=0 with req0 continuously valid → exactly 4 accepts, then `req_ready[0]`=0 while req1 receives all grants.
  - Raising `rsp_ready[0]` drains 4 results in order; `req_ready[0]` returns one cycle after the first pop.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF → `rsp_y` exponent 255 and `rsp_ovf`=1 on the correct lane.
- Reset mid-operation:
  - Stimulus: `rst` pulsed with 3 results in flight and 2 buffered.
  - Required response: all outputs are 0 during reset; `rsp_valid`=0 for LAT+3 cycles after release; a new request then completes normally.

Source files
------------

// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter: shares one fixed-latency fsub pipeline between two
// requesters. Addition is done on the subtractor by inverting the sign of
// operand 2. Grants are round-robin. Each requester has its own response FIFO.
// Credits count in-flight plus buffered results, so a stalled consumer only
// throttles its own requester.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. A response pops on a rising edge where
// rsp_valid[i] and rsp_ready[i] are both high. req_ready is combinational from
// registered state and req_valid. rsp_valid depends on registered state only.
module fpu_addsub_arbiter #(
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_sub,
  input  logic [63:0] req_x1,
  input  logic [63:0] req_x2,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_y,
  output logic [1:0]  rsp_ovf,
  output logic [31:0] fpu_x1,
  output logic [31:0] fpu_x2,
  input  logic [31:0] fpu_y,
  input  logic        fpu_ovf
);

  // Counter width holds 0..DEPTH; the credit sum needs one extra bit.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        accept;
  logic        acc_id;
  logic        last;

  logic [31:0] sel_x1;
  logic [31:0] sel_x2;
  logic        sel_sub;

  logic [LAT:0] vld;
  logic [LAT:0] id;
  logic         wb_vld;
  logic         wb_id;

  logic [1:0]  fifo_wr;
  logic [1:0]  fifo_pop;
  logic [1:0]  fifo_full;

  // Round-robin pick: a single eligible requester wins; on a tie the one that
  // was not granted last wins. Nothing is granted while reset is held.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (elig == 2'b11) begin
        grant = last ? 2'b01 : 2'b10;
      end else begin
        grant = elig;
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign acc_id    = grant[1];

  assign sel_x1  = acc_id ? req_x1[63:32] : req_x1[31:0];
  assign sel_x2  = acc_id ? req_x2[63:32] : req_x2[31:0];
  assign sel_sub = acc_id ? req_sub[1]    : req_sub[0];

  // Issue register: the accepted operands go to fsub, and operand 2's sign is
  // flipped for an add. Idle cycles present zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_x1 <= '0;
      fpu_x2 <= '0;
    end else if (accept) begin
      fpu_x1 <= sel_x1;
      fpu_x2 <= {sel_x2[31] ^ ~sel_sub, sel_x2[30:0]};
    end else begin
      fpu_x1 <= '0;
      fpu_x2 <= '0;
    end
  end

  // Remember the most recent grant for the round-robin tie break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= acc_id;
    end
  end

  // Tag pipe that shadows the fsub pipeline. Stage LAT marks the cycle where
  // fpu_y belongs to an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      id  <= '0;
    end else begin
      vld <= {vld[LAT-1:0], accept};
      id  <= {id[LAT-1:0], acc_id};
    end
  end

  assign wb_vld = vld[LAT];
  assign wb_id  = id[LAT];

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [CW-1:0] infl;
    logic [CW-1:0] occ;
    logic [CW:0]   committed;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [32:0]   mem [DEPTH];

    assign committed    = {1'b0, infl} + {1'b0, occ};
    assign elig[g]      = req_valid[g] && (committed < CREDITS);
    assign fifo_wr[g]   = wb_vld && (wb_id == 1'(g));
    assign rsp_valid[g] = (occ != '0);
    assign fifo_pop[g]  = rsp_valid[g] && rsp_ready[g];
    assign fifo_full[g] = (occ == OCC_FULL);

    // Head of the FIFO drives the response lane and reads as zero when empty.
    assign rsp_y[32*g +: 32] = rsp_valid[g] ? mem[rd_ptr][31:0] : 32'd0;
    assign rsp_ovf[g]        = rsp_valid[g] & mem[rd_ptr][32];

    // In-flight count: up on accept, down when the result lands in the FIFO.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        infl <= '0;
      end else begin
        case ({grant[g], fifo_wr[g]})
          2'b10:   infl <= infl + CNT_ONE;
          2'b01:   infl <= infl - CNT_ONE;
          default: infl <= infl;
        endcase
      end
    end

    // Occupancy: a write and a pop in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        occ <= '0;
      end else begin
        case ({fifo_wr[g], fifo_pop[g]})
          2'b10:   occ <= occ + CNT_ONE;
          2'b01:   occ <= occ - CNT_ONE;
          default: occ <= occ;
        endcase
      end
    end

    // Circular pointers wrap at DEPTH, which need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (fifo_wr[g]) begin
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
        end
        if (fifo_pop[g]) begin
          rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
        end
      end
    end

    // Result storage. Entries are qualified by occ, so they need no reset.
    always_ff @(posedge clk) begin
      if (fifo_wr[g]) begin
        mem[wr_ptr] <= {fpu_ovf, fpu_y};
      end
    end
  end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter. It contains a behavioural fsub (IEEE single
// values computed through real arithmetic) and a queue-level model of grants,
// credits and per-requester response order. That model is compared with the
// DUT on every falling edge.
module tb_fpu_addsub_arbiter;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, req_sub, rsp_valid, rsp_ready, rsp_ovf;
  logic [63:0] req_x1, req_x2, rsp_y;
  logic [31:0] fpu_x1, fpu_x2, fpu_y;
  logic        fpu_ovf;

  int total = 0;
  int bad   = 0;

  fpu_addsub_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_x1(req_x1), .req_x2(req_x2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf),
    .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y), .fpu_ovf(fpu_ovf)
  );

  // ---------------- float helpers ----------------
  function automatic real sp2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Returns {ovf, single}; truncating conversion, saturating to infinity.
  function automatic logic [32:0] r2sp(input real r);
    logic [63:0] d;
    int se;
    d  = $realtobits(r);
    se = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0) return {1'b0, d[63], 31'd0};
    if (se >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    if (se <= 0) return {1'b0, d[63], 31'd0};
    return {1'b0, d[63], se[7:0], d[51:29]};
  endfunction

  // What a request must produce: x1 - x2 or x1 + x2.
  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub);
    return r2sp(sub ? sp2r(a) - sp2r(b) : sp2r(a) + sp2r(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // ---------------- behavioural fsub, LAT stages ----------------
  logic [32:0] fs_pipe [1:LAT];
  always @(posedge clk) begin
    fs_pipe[1] <= r2sp(sp2r(fpu_x1) - sp2r(fpu_x2));
    for (int k = 2; k <= LAT; k++) fs_pipe[k] <= fs_pipe[k-1];
  end
  assign fpu_y   = fs_pipe[LAT][31:0];
  assign fpu_ovf = fs_pipe[LAT][32];

  // ---------------- reference model ----------------
  typedef struct {
    logic [32:0] r;
    int          due;
  } infl_t;

  infl_t       m_if0[$], m_if1[$];
  logic [32:0] exp_q0[$], exp_q1[$];
  logic        m_last = 1'b1;
  logic [31:0] m_fx1  = '0;
  logic [31:0] m_fx2  = '0;
  int          mcyc   = 0;

  function automatic logic [1:0] model_grant();
    logic [1:0] e;
    e[0] = req_valid[0] && (m_if0.size() + exp_q0.size() < DEPTH);
    e[1] = req_valid[1] && (m_if1.size() + exp_q1.size() < DEPTH);
    if (rst) return 2'b00;
    if (e == 2'b11) return m_last ? 2'b01 : 2'b10;
    return e;
  endfunction

  initial begin
    forever begin
      logic [1:0]  g;
      logic        s;
      logic [31:0] a, b;
      logic        sb;
      infl_t       t;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_if0.delete(); m_if1.delete(); exp_q0.delete(); exp_q1.delete();
        m_last = 1'b1; m_fx1 = '0; m_fx2 = '0;
      end else begin
        g = model_grant();
        mcyc++;
        if (exp_q0.size() > 0 && rsp_ready[0]) void'(exp_q0.pop_front());
        if (exp_q1.size() > 0 && rsp_ready[1]) void'(exp_q1.pop_front());
        if (m_if0.size() > 0 && m_if0[0].due == mcyc) begin
          t = m_if0.pop_front(); exp_q0.push_back(t.r);
        end
        if (m_if1.size() > 0 && m_if1[0].due == mcyc) begin
          t = m_if1.pop_front(); exp_q1.push_back(t.r);
        end
        if (g != 2'b00) begin
          s  = g[1];
          a  = s ? req_x1[63:32] : req_x1[31:0];
          b  = s ? req_x2[63:32] : req_x2[31:0];
          sb = s ? req_sub[1] : req_sub[0];
          m_fx1 = a;
          m_fx2 = sb ? b : {~b[31], b[30:0]};
          t.r   = ref_op(a, b, sb);
          t.due = mcyc + LAT + 1;
          if (s) m_if1.push_back(t); else m_if0.push_back(t);
          m_last = s;
        end else begin
          m_fx1 = '0; m_fx2 = '0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT against the model.
  initial begin
    forever begin
      logic [1:0] ev;
      @(negedge clk);
      chk("req_ready", req_ready, model_grant());
      ev = {exp_q1.size() > 0, exp_q0.size() > 0};
      chk("rsp_valid", rsp_valid, ev);
      if (ev[0]) begin
        chk("rsp_y0", rsp_y[31:0], exp_q0[0][31:0]);
        chk("rsp_ovf0", rsp_ovf[0], exp_q0[0][32]);
      end
      if (ev[1]) begin
        chk("rsp_y1", rsp_y[63:32], exp_q1[0][31:0]);
        chk("rsp_ovf1", rsp_ovf[1], exp_q1[0][32]);
      end
      chk("fpu_x1", fpu_x1, m_fx1);
      chk("fpu_x2", fpu_x2, m_fx2);
      chk("write_into_full", dut.fifo_wr & dut.fifo_full, 2'b00);
      if (rst) begin
        chk("rst_rsp_y", rsp_y, 64'd0);
        chk("rst_rsp_ovf", rsp_ovf, 2'b00);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] v, input logic [1:0] sb, input logic [63:0] a,
                       input logic [63:0] b, input logic [1:0] rr);
    req_valid = v; req_sub = sb; req_x1 = a; req_x2 = b; rsp_ready = rr;
  endtask

  task automatic drive_rand(input logic [1:0] v, input logic [1:0] rr);
    drive(v, 2'($urandom_range(0, 3)), {rnd_fp(), rnd_fp()}, {rnd_fp(), rnd_fp()}, rr);
  endtask

  task automatic idle(input int n);
    drive(2'b00, 2'b00, 64'd0, 64'd0, 2'b11);
    repeat (n) step();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc0;
    rst = 1'b0;
    drive(2'b11, 2'b00, 64'd0, 64'd0, 2'b11);
    #1 rst = 1'b1;
    repeat (2) step();
    at_neg();
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_fpu_x1", fpu_x1, 32'd0);
    chk("reset_fpu_x2", fpu_x2, 32'd0);
    step();
    rst = 1'b0;
    idle(1);

    // Add on requester 0: 1.0 + 2.0
    drive(2'b01, 2'b00, {32'd0, 32'h3F800000}, {32'd0, 32'h40000000}, 2'b11);
    at_neg(); chk("add_ready", req_ready, 2'b01);
    step(); idle(0);
    at_neg();
    chk("add_fpu_x1", fpu_x1, 32'h3F800000);
    chk("add_fpu_x2", fpu_x2, 32'hC0000000);
    step(); at_neg(); chk("add_not_yet", rsp_valid[0], 1'b0);
    step(); at_neg();
    chk("add_valid", rsp_valid[0], 1'b1);
    chk("add_y", rsp_y[31:0], 32'h40400000);
    chk("add_ovf", rsp_ovf[0], 1'b0);
    idle(2);

    // Subtract on requester 1: 1.0 - 2.0
    drive(2'b10, 2'b10, {32'h3F800000, 32'd0}, {32'h40000000, 32'd0}, 2'b11);
    at_neg(); chk("sub_ready", req_ready, 2'b10);
    step(); idle(0);
    at_neg(); chk("sub_fpu_x2", fpu_x2, 32'h40000000);
    step(); step(); at_neg();
    chk("sub_valid", rsp_valid[1], 1'b1);
    chk("sub_y", rsp_y[63:32], 32'hBF800000);
    idle(3);

    // Contention: grants alternate starting with requester 0
    for (int k = 0; k < 8; k++) begin
      drive_rand(2'b11, 2'b11);
      at_neg(); chk("contention_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    idle(6);

    // Backpressure: consumer 0 stalled
    acc0 = 0;
    for (int k = 0; k < 12; k++) begin
      drive_rand(2'b11, 2'b10);
      at_neg();
      if (req_ready[0]) acc0++;
      if (k >= 8) chk("bp_only_req1", req_ready, 2'b10);
      step();
    end
    chk("bp_accepts", acc0, 4);
    drive_rand(2'b11, 2'b11);
    at_neg(); chk("bp_pop_cycle_ready0", req_ready[0], 1'b0);
    step();
    drive_rand(2'b11, 2'b11);
    at_neg(); chk("bp_ready0_back", req_ready[0], 1'b1);
    step();
    for (int k = 0; k < 6; k++) begin drive_rand(2'b11, 2'b11); step(); end
    idle(8);

    // Overflow on lane 1: FLT_MAX + FLT_MAX
    drive(2'b10, 2'b00, {32'h7F7FFFFF, 32'd0}, {32'h7F7FFFFF, 32'd0}, 2'b11);
    step(); idle(0); step(); step(); at_neg();
    chk("ovf_exp", rsp_y[62:55], 8'hFF);
    chk("ovf_flag", rsp_ovf, 2'b10);
    idle(3);

    // Reset with results in flight and buffered
    for (int k = 0; k < 5; k++) begin drive_rand(2'b11, 2'b00); step(); end
    rst = 1'b1;
    at_neg();
    chk("midrst_req_ready", req_ready, 2'b00);
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_fpu_x", {fpu_x1, fpu_x2}, 64'd0);
    step();
    rst = 1'b0;
    idle(0);
    for (int k = 0; k < LAT + 3; k++) begin
      at_neg(); chk("post_rst_quiet", rsp_valid, 2'b00); step();
    end
    drive(2'b01, 2'b00, {32'd0, 32'h3F800000}, {32'd0, 32'h40000000}, 2'b11);
    step(); idle(0); step(); step(); at_neg();
    chk("post_rst_valid", rsp_valid[0], 1'b1);
    chk("post_rst_y", rsp_y[31:0], 32'h40400000);
    idle(3);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      drive_rand(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      step();
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
